// File: rtl/rf_write_port_if.sv
// Signal bundle between the write-port merger and its neighbours: WB, JAL link,
// multiply/divide handshake and issue, decode hazard query, and register-file write.
interface rf_write_port_if;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        jal_valid;
    logic [29:0] jal_pc4;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        md_issue;
    logic [4:0]  md_issue_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        stall;
    logic        rf_wr;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        link_ovf;

    modport master (
        output wb_valid, wb_addr, wb_data, jal_valid, jal_pc4,
        output md_valid, md_addr, md_data, md_issue, md_issue_addr, rs_addr, rt_addr,
        input  md_ready, stall, rf_wr, rf_a3, rf_wd, link_ovf
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, jal_valid, jal_pc4,
        input  md_valid, md_addr, md_data, md_issue, md_issue_addr, rs_addr, rt_addr,
        output md_ready, stall, rf_wr, rf_a3, rf_wd, link_ovf
    );
endinterface

// File: rtl/rf_write_port.sv
// Merges WB, JAL link and multiply/divide writes onto the single register-file write port,
// with a one-entry link buffer and a pending-write scoreboard for decode stalls.
module rf_write_port (
    input logic             clk,
    input logic             rst,
    rf_write_port_if.slave  bus
);

    logic        rf_wr_q;
    logic [4:0]  rf_a3_q;
    logic [31:0] rf_wd_q;
    logic        link_full_q, link_full_d;
    logic [31:0] link_val_q, link_val_d;
    logic        link_ovf_q, link_ovf_d;
    logic [31:0] pending_q, pending_d;

    logic        sel;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic        md_xfer;
    logic [31:0] link_new;

    assign link_new     = {bus.jal_pc4 + 30'd1, 2'b00};
    assign bus.md_ready = !bus.wb_valid && !bus.jal_valid && !link_full_q;

    always_comb begin
        sel         = 1'b0;
        sel_addr    = 5'd0;
        sel_data    = 32'd0;
        md_xfer     = 1'b0;
        link_full_d = link_full_q;
        link_val_d  = link_val_q;
        link_ovf_d  = link_ovf_q;
        if (bus.wb_valid) begin
            sel      = 1'b1;
            sel_addr = bus.wb_addr;
            sel_data = bus.wb_data;
            // WB owns the port, so a JAL link must wait in the buffer or be lost.
            if (bus.jal_valid) begin
                if (link_full_q) begin
                    link_ovf_d = 1'b1;
                end else begin
                    link_full_d = 1'b1;
                    link_val_d  = link_new;
                end
            end
        end else if (link_full_q) begin
            sel         = 1'b1;
            sel_addr    = 5'd31;
            sel_data    = link_val_q;
            link_full_d = bus.jal_valid;
            if (bus.jal_valid) begin
                link_val_d = link_new;
            end
        end else if (bus.jal_valid) begin
            sel      = 1'b1;
            sel_addr = 5'd31;
            sel_data = link_new;
        end else if (bus.md_valid) begin
            sel      = 1'b1;
            sel_addr = bus.md_addr;
            sel_data = bus.md_data;
            md_xfer  = 1'b1;
        end
    end

    // Issue is applied after the transfer clear so a same-register set wins.
    always_comb begin
        pending_d = pending_q;
        if (md_xfer) begin
            pending_d[bus.md_addr] = 1'b0;
        end
        if (bus.md_issue) begin
            pending_d[bus.md_issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign bus.stall = ((bus.rs_addr != 5'd0) && pending_q[bus.rs_addr]) ||
                       ((bus.rt_addr != 5'd0) && pending_q[bus.rt_addr]);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_q     <= 1'b0;
            rf_a3_q     <= 5'd0;
            rf_wd_q     <= 32'd0;
            link_full_q <= 1'b0;
            link_val_q  <= 32'd0;
            link_ovf_q  <= 1'b0;
            pending_q   <= 32'd0;
        end else begin
            rf_wr_q     <= sel && (sel_addr != 5'd0);
            if (sel) begin
                rf_a3_q <= sel_addr;
                rf_wd_q <= sel_data;
            end
            link_full_q <= link_full_d;
            link_val_q  <= link_val_d;
            link_ovf_q  <= link_ovf_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.rf_wr    = rf_wr_q;
    assign bus.rf_a3    = rf_a3_q;
    assign bus.rf_wd    = rf_wd_q;
    assign bus.link_ovf = link_ovf_q;

endmodule

// File: tb/tb_rf_write_port.sv
// Table-driven bench for rf_write_port: per-cycle stimulus with expected writes queued
// at drive time and popped after the clock edge.
module tb_rf_write_port;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_write_port_if bus ();

    rf_write_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        wb_v;
        logic [4:0]  wb_a;
        logic [31:0] wb_d;
        logic        jal_v;
        logic [29:0] pc4;
        logic        md_v;
        logic [4:0]  md_a;
        logic [31:0] md_d;
        logic        iss;
        logic [4:0]  iss_a;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        exp_stall;
        logic        exp_mdr;
        logic        exp_wr;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [4:0]  a3;
        logic [31:0] wd;
    } wr_t;

    vec_t tbl[$];
    wr_t  exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(
        input int unsigned r, wv, wa, wd, jv, pc, mv, ma, md, iv, ia, rs, rt,
        input int unsigned st, mr, ew, ea, ed, ovf);
        vec_t v;
        v.rst = r[0];     v.wb_v = wv[0];   v.wb_a = wa[4:0];  v.wb_d = wd;
        v.jal_v = jv[0];  v.pc4 = pc[29:0]; v.md_v = mv[0];    v.md_a = ma[4:0];
        v.md_d = md;      v.iss = iv[0];    v.iss_a = ia[4:0]; v.rs = rs[4:0];
        v.rt = rt[4:0];   v.exp_stall = st[0]; v.exp_mdr = mr[0]; v.exp_wr = ew[0];
        v.exp_a3 = ea[4:0]; v.exp_wd = ed; v.exp_ovf = ovf[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst               = v.rst;
        bus.wb_valid      = v.wb_v;
        bus.wb_addr       = v.wb_a;
        bus.wb_data       = v.wb_d;
        bus.jal_valid     = v.jal_v;
        bus.jal_pc4       = v.pc4;
        bus.md_valid      = v.md_v;
        bus.md_addr       = v.md_a;
        bus.md_data       = v.md_d;
        bus.md_issue      = v.iss;
        bus.md_issue_addr = v.iss_a;
        bus.rs_addr       = v.rs;
        bus.rt_addr       = v.rt;
    endtask

    // After the edge: pop the expectation queued for this cycle and compare the port.
    task automatic check_write(input string nm);
        wr_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, rf_wr=%0b", nm, bus.rf_wr);
            return;
        end
        e = exp_q.pop_front();
        chk({nm, " rf_wr"}, {31'd0, bus.rf_wr}, {31'd0, e.wr});
        if (e.wr) begin
            chk({nm, " rf_a3"}, {27'd0, bus.rf_a3}, {27'd0, e.a3});
            chk({nm, " rf_wd"}, bus.rf_wd, e.wd);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        wr_t e;
        string nm;
        nm = $sformatf("v%0d", idx);
        drive(v);
        #1;
        chk({nm, " stall"}, {31'd0, bus.stall}, {31'd0, v.exp_stall});
        chk({nm, " md_ready"}, {31'd0, bus.md_ready}, {31'd0, v.exp_mdr});
        e.wr = v.exp_wr;
        e.a3 = v.exp_a3;
        e.wd = v.exp_wd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_write(nm);
        chk({nm, " link_ovf"}, {31'd0, bus.link_ovf}, {31'd0, v.exp_ovf});
        @(negedge clk);
    endtask

    initial begin
        vec_t z;
        wr_t  e;
        bit   got;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        drive(z);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset rf_wr", {31'd0, bus.rf_wr}, 32'd0);
        chk("reset rf_a3", {27'd0, bus.rf_a3}, 32'd0);
        chk("reset rf_wd", bus.rf_wd, 32'd0);
        chk("reset link_ovf", {31'd0, bus.link_ovf}, 32'd0);
        chk("reset stall", {31'd0, bus.stall}, 32'd0);
        chk("reset md_ready", {31'd0, bus.md_ready}, 32'd1);
        @(negedge clk);

        //             r wv wa wd            jv pc       mv ma md            iv ia rs rt
        //             st mr ew ea ed           ovf
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 1, 5, 32'h1234_5678, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h1000, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 1, 31, 32'h0000_4004, 0));
        tbl.push_back(mk(0, 1, 2, 'hA, 1, 'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 'hA, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 'h4004, 0));
        // Three cycles of WB+JAL: first link buffered, next two dropped.
        tbl.push_back(mk(0, 1, 1, 1, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 3, 3, 1, 'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 1));
        tbl.push_back(mk(0, 1, 4, 4, 1, 'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 'h44, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // Drain and refill in the same cycle.
        tbl.push_back(mk(0, 1, 6, 6, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 6, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 'h404, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 'h804, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // Scoreboard: issue r8, md result held through WB traffic.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 8, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 10, 'h10, 0, 0, 1, 8, 32'hDEAD_BEEF, 0, 0, 8, 0,
                         1, 0, 1, 10, 'h10, 1));
        tbl.push_back(mk(0, 1, 11, 'h11, 0, 0, 1, 8, 32'hDEAD_BEEF, 0, 0, 8, 0,
                         1, 0, 1, 11, 'h11, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8, 32'hDEAD_BEEF, 0, 0, 8, 0,
                         1, 1, 1, 8, 32'hDEAD_BEEF, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0, 1));
        // Same-register set and clear in one cycle: set wins.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 12, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 12, 5, 1, 12, 0, 12, 1, 1, 1, 12, 5, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 12, 6, 0, 0, 0, 12, 1, 1, 1, 12, 6, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 1, 0, 0, 0, 1));
        // r0 writes and issues are inert.
        tbl.push_back(mk(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // JAL beats a waiting md result.
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 1, 7, 7, 0, 0, 0, 0, 0, 0, 1, 31, 'h10, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 0, 1, 1, 7, 7, 1));
        // Reset with a full link buffer and r9 pending.
        tbl.push_back(mk(0, 1, 1, 1, 1, 'h40, 0, 0, 0, 1, 9, 0, 0, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(1, 1, 2, 2, 1, 'h50, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0));

        foreach (tbl[i]) run_vec(i, tbl[i]);

        // Hand sequence: md result r20 offered under WB, then waited for with a bound.
        z = mk(0, 1, 21, 'h21, 0, 0, 1, 20, 32'hCAFE_0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
        e.wr = 1'b1; e.a3 = 5'd21; e.wd = 32'h21;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_write("md_wait wb");
        @(negedge clk);
        bus.wb_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 5 && !got; c++) begin
            #1;
            if (bus.md_ready) begin
                got = 1'b1;
                e.wr = 1'b1; e.a3 = 5'd20; e.wd = 32'hCAFE_0001;
            end else begin
                e.wr = 1'b0; e.a3 = 5'd0; e.wd = 32'd0;
            end
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            check_write($sformatf("md_wait c%0d", c));
            @(negedge clk);
            if (got) bus.md_valid = 1'b0;
        end
        chk("md_wait accepted", {31'd0, got}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_write_port.md
# rf_write_port

Writer side of the CPU register file. Merges every source of register writes onto the file's single write port (A3/WD/RFWr) as one registered write per cycle: WB-stage results, JAL link values and results from the multi-cycle multiply/divide unit. Also keeps a pending-write scoreboard so the decode stage stalls on registers the multiply/divide unit has not yet written. Sits between the WB stage, the multiply/divide unit and the register file.

## Interface
Parameters:
- none; register index width is 5 and data width is 32, fixed.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_valid  in  1  WB stage has a result this cycle; cannot be stalled.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB result.
- jal_valid  in  1  JAL retiring; link value must be written to r31.
- jal_pc4  in  30  word address of the JAL's PC+4; link value = {jal_pc4 + 1, 2'b00}.
- md_valid  in  1  multiply/divide result offered.
- md_addr  in  5  multiply/divide destination register.
- md_data  in  32  multiply/divide result.
- md_ready  out  1  result accepted this cycle when md_valid && md_ready.
- md_issue  in  1  multiply/divide operation issued; mark md_issue_addr pending.
- md_issue_addr  in  5  destination of the issued operation.
- rs_addr, rt_addr  in  5 each  decode-stage source registers.
- stall  out  1  rs_addr or rt_addr is pending (combinational).
- rf_wr  out  1  register-file write enable (drives RFWr).
- rf_a3  out  5  write address (drives A3).
- rf_wd  out  32  write data (drives WD).
- link_ovf  out  1  sticky: a JAL link value was dropped.

## Operation
- Every cycle, at most one source is selected. Fixed priority: WB, then the link path (buffered link first, then a new JAL), then multiply/divide.
- A selected write is registered into rf_wr/rf_a3/rf_wd at the next edge. With nothing selected, rf_wr=0 and rf_a3/rf_wd hold their previous values.
- Any selected write with address 0 is consumed but produces rf_wr=0.
- Link path:
  - There is one link buffer entry (link_full, link_val).
  - JAL with no WB and an empty buffer: written directly.
  - JAL in the same cycle as WB: the link value goes into the buffer.
  - Buffer full, no WB: the buffer drains. A JAL arriving in that same cycle refills the buffer.
  - Buffer full, and both WB and JAL arrive: the new link is dropped, link_ovf is set, and the buffer is kept.
- md_ready = !wb_valid && !jal_valid && !link_full (combinational). A transfer happens only when md_valid && md_ready. md_valid and md fields must stay stable until the transfer.
- Scoreboard (32 pending bits; bit 0 is never set):
  - md_issue sets pending[md_issue_addr].
  - An md transfer clears pending[md_addr].
  - If set and clear hit the same register in the same cycle, set wins.
- stall = (rs_addr!=0 && pending[rs_addr]) || (rt_addr!=0 && pending[rt_addr]).
- Reset clears: rf_wr, rf_a3, rf_wd, link_full, link_val, link_ovf and all pending bits. md_ready and stall then follow their equations (stall=0).
- Reset asserted mid-operation: buffered links and pending bits are discarded. No write is emitted in the reset cycle or the cycle after it.

## Timing
- Write latency: a source is accepted in cycle N and appears on rf_wr/rf_a3/rf_wd in cycle N+1.
- A buffered link written the cycle after its JAL has latency 2. Each further cycle of continuous WB adds 1.
- link_ovf is set in the cycle after the overflow event and clears only on rst.
- A pending bit is visible on stall the cycle after md_issue. It clears the cycle after the md transfer, the same cycle the write appears on rf_wr.
- stall, md_ready: combinational from current inputs and state, with no registered delay.

## Test plan
- Reset then idle: all outputs 0. WB r5=0x1234_5678 in cycle 3 -> cycle 4 has rf_wr=1, rf_a3=5, rf_wd=0x1234_5678.
- JAL with jal_pc4=0x0000_1000 alone -> next cycle writes r31=0x0000_4004. Same JAL together with WB r2=0xA -> r2=0xA written first, r31=0x0000_4004 the following cycle.
- Three consecutive cycles of WB plus JAL (pc4 0x10, 0x20, 0x30) -> link 0x44 buffered, later links dropped, link_ovf=1. The buffer drains once WB stops.
- md_issue r8, then decode rs_addr=8 -> stall=1 from the next cycle. md_valid r8=0xDEAD_BEEF held during WB traffic -> md_ready=0 until WB idles. After the transfer, rf_wr writes r8 and stall=0 that same cycle.
- WB to r0 with data 0xFFFF_FFFF -> rf_wr stays 0. md_issue r0 -> stall never asserts for rs_addr=0.
- rst asserted while the link buffer is full and r9 is pending -> no r31 write afterwards, stall=0 for rs_addr=9, link_ovf=0.
